// File: rtl/intersection_pkg.sv
// Shared state encoding, phase numbering, default timing and lamp decode
// for the four-way intersection controller.
package intersection_pkg;

    typedef enum logic [2:0] {
        ST_ALL_RED,
        ST_GREEN,
        ST_YELLOW,
        ST_PED,
        ST_BLINK
    } state_e;

    localparam logic [1:0] PH_TH  = 2'd0;
    localparam logic [1:0] PH_NN  = 2'd1;
    localparam logic [1:0] PH_NS  = 2'd2;
    localparam logic [1:0] PH_PED = 2'd3;

    localparam int unsigned DEF_TICKS_PER_MS = 10;
    localparam int unsigned DEF_T_MIN_GREEN  = 10000;
    localparam int unsigned DEF_T_MAX_GREEN  = 30000;
    localparam int unsigned DEF_T_YELLOW     = 3000;
    localparam int unsigned DEF_T_ALL_RED    = 1000;
    localparam int unsigned DEF_T_PED        = 8000;
    localparam int unsigned DEF_T_BLINK      = 500;

    typedef struct packed {
        logic th_g;
        logic th_y;
        logic th_r;
        logic nn_g;
        logic nn_y;
        logic nn_r;
        logic ns_g;
        logic ns_y;
        logic ns_r;
        logic gth_g;
        logic gth_r;
        logic gnn_g;
        logic gnn_r;
        logic ped_n_g;
        logic ped_n_r;
        logic ped_th_g;
        logic ped_th_r;
    } lamps_t;

    localparam lamps_t LAMPS_ALL_RED = '{
        th_r: 1'b1, nn_r: 1'b1, ns_r: 1'b1, gth_r: 1'b1, gnn_r: 1'b1,
        ped_n_r: 1'b1, ped_th_r: 1'b1, default: 1'b0
    };

    function automatic lamps_t lamp_decode(input state_e st, input logic [1:0] cur,
                                           input logic blink);
        lamps_t l;
        logic   grn;
        grn = (st == ST_GREEN);
        l   = LAMPS_ALL_RED;
        if (st == ST_BLINK) begin
            l      = '0;
            l.th_y = blink;
            l.nn_y = blink;
            l.ns_y = blink;
        end else if (st == ST_GREEN || st == ST_YELLOW) begin
            case (cur)
                PH_TH: begin
                    l.th_r  = 1'b0;
                    l.th_g  = grn;
                    l.th_y  = ~grn;
                    l.gth_g = grn;
                    l.gth_r = ~grn;
                end
                PH_NN: begin
                    l.nn_r  = 1'b0;
                    l.nn_g  = grn;
                    l.nn_y  = ~grn;
                    l.gnn_g = grn;
                    l.gnn_r = ~grn;
                end
                PH_NS: begin
                    l.ns_r = 1'b0;
                    l.ns_g = grn;
                    l.ns_y = ~grn;
                end
                default: ;
            endcase
        end else if (st == ST_PED) begin
            l.ped_n_g  = 1'b1;
            l.ped_n_r  = 1'b0;
            l.ped_th_g = 1'b1;
            l.ped_th_r = 1'b0;
        end
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Millisecond timebase: prescaler plus a saturating ms counter, both cleared
// by `clear`; ms_next exposes the value the counter takes on the coming edge.
module phase_timer #(
    parameter int unsigned TICKS_PER_MS = 10,
    parameter int unsigned MS_MAX       = 30000
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        clear,
    output logic        tick,
    output logic [31:0] ms,
    output logic [31:0] ms_next
);

    localparam int unsigned PRE_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_MS - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [31:0]      ms_q, ms_d;

    assign tick = (pre_q == PRE_LAST);

    // NOTE: every variable gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
        ms_d  = ms_q;
        if (pre_q == PRE_LAST && ms_q < 32'(MS_MAX)) begin
            ms_d = ms_q + 32'd1;
        end
        if (clear) begin
            pre_d = '0;
            ms_d  = '0;
        end
    end

    // NOTE: non-blocking assignments, so every flop samples pre-edge values
    // regardless of statement order.
    always_ff @(posedge CLK) begin
        if (reset) begin
            pre_q <= '0;
            ms_q  <= '0;
        end else begin
            pre_q <= pre_d;
            ms_q  <= ms_d;
        end
    end

    assign ms      = ms_q;
    assign ms_next = ms_d;

endmodule

// File: rtl/intersection_sequencer.sv
// Four-way intersection phase controller: round-robin service of latched
// vehicle/pedestrian requests with min/max green, yellow, all-red and blink.
module intersection_sequencer
    import intersection_pkg::*;
#(
    parameter int unsigned TICKS_PER_MS = DEF_TICKS_PER_MS,
    parameter int unsigned T_MIN_GREEN  = DEF_T_MIN_GREEN,
    parameter int unsigned T_MAX_GREEN  = DEF_T_MAX_GREEN,
    parameter int unsigned T_YELLOW     = DEF_T_YELLOW,
    parameter int unsigned T_ALL_RED    = DEF_T_ALL_RED,
    parameter int unsigned T_PED        = DEF_T_PED,
    parameter int unsigned T_BLINK      = DEF_T_BLINK
) (
    input  logic CLK,
    input  logic reset,
    input  logic en,
    input  logic sens_th,
    input  logic sens_nn,
    input  logic sens_ns,
    input  logic btn_n,
    input  logic btn_th,
    output logic th_g,
    output logic th_y,
    output logic th_r,
    output logic nn_g,
    output logic nn_y,
    output logic nn_r,
    output logic ns_g,
    output logic ns_y,
    output logic ns_r,
    output logic gth_g,
    output logic gth_r,
    output logic gnn_g,
    output logic gnn_r,
    output logic ped_n_g,
    output logic ped_n_r,
    output logic ped_th_g,
    output logic ped_th_r
);

    state_e      state_q, state_d;
    logic [1:0]  cur_q, cur_d;
    logic [3:0]  req_q, req_d;
    logic [4:0]  sync1_q, sync1_d, sync2_q, sync2_d;
    lamps_t      lamps_q, lamps_d;

    logic [3:0]  req_set, req_clr, cur_oh;
    logic [1:0]  pick;
    logic        pend;
    logic        blink_wrap;
    logic        timer_clear;
    logic        tick;
    logic [31:0] ms_cnt, ms_next;

    phase_timer #(
        .TICKS_PER_MS(TICKS_PER_MS),
        .MS_MAX      (T_MAX_GREEN)
    ) u_timer (
        .CLK    (CLK),
        .reset  (reset),
        .clear  (timer_clear),
        .tick   (tick),
        .ms     (ms_cnt),
        .ms_next(ms_next)
    );

    always_comb begin
        sync1_d = {btn_th, btn_n, sens_ns, sens_nn, sens_th};
        sync2_d = sync1_q;
        req_set = {sync2_q[4] | sync2_q[3], sync2_q[2], sync2_q[1], sync2_q[0]};
        req_clr = '0;
        cur_oh  = 4'b0001 << cur_q;
        pend    = ((req_q & ~cur_oh) != 4'b0000) || (cur_q != PH_TH);

        // Walk cur+4 down to cur+1 so the nearest set request wins.
        pick = PH_TH;
        for (int k = 4; k >= 1; k--) begin
            if (req_q[cur_q + 2'(k)]) begin
                pick = cur_q + 2'(k);
            end
        end

        state_d = state_q;
        cur_d   = cur_q;
        if (!en) begin
            state_d = ST_BLINK;
        end else begin
            case (state_q)
                ST_ALL_RED: begin
                    if (ms_cnt >= 32'(T_ALL_RED)) begin
                        cur_d   = pick;
                        req_clr = 4'b0001 << pick;
                        state_d = (pick == PH_PED) ? ST_PED : ST_GREEN;
                    end
                end
                ST_GREEN: begin
                    if (pend && (ms_cnt >= 32'(T_MIN_GREEN) || ms_cnt >= 32'(T_MAX_GREEN))) begin
                        state_d = ST_YELLOW;
                    end
                end
                ST_YELLOW: if (ms_cnt >= 32'(T_YELLOW)) state_d = ST_ALL_RED;
                ST_PED:    if (ms_cnt >= 32'(T_PED))    state_d = ST_ALL_RED;
                default:   state_d = ST_ALL_RED;
            endcase
        end

        req_d = (req_q | req_set) & ~req_clr;

        // Blink restarts the timer each full period so the flash never stalls
        // against the counter's saturation point.
        blink_wrap  = (state_q == ST_BLINK) && (state_d == ST_BLINK) && tick
                      && (ms_cnt == 32'(2 * T_BLINK - 1));
        timer_clear = (state_d != state_q) || blink_wrap;
    end

    // ms_next stays below 2*T_BLINK in blink, so the compare is bit 0 of ms/T_BLINK.
    always_comb begin
        lamps_d = lamp_decode(state_d, cur_d, ms_next >= 32'(T_BLINK));
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= ST_ALL_RED;
            cur_q   <= PH_PED;
            req_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            lamps_q <= LAMPS_ALL_RED;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            req_q   <= req_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            lamps_q <= lamps_d;
        end
    end

    assign th_g     = lamps_q.th_g;
    assign th_y     = lamps_q.th_y;
    assign th_r     = lamps_q.th_r;
    assign nn_g     = lamps_q.nn_g;
    assign nn_y     = lamps_q.nn_y;
    assign nn_r     = lamps_q.nn_r;
    assign ns_g     = lamps_q.ns_g;
    assign ns_y     = lamps_q.ns_y;
    assign ns_r     = lamps_q.ns_r;
    assign gth_g    = lamps_q.gth_g;
    assign gth_r    = lamps_q.gth_r;
    assign gnn_g    = lamps_q.gnn_g;
    assign gnn_r    = lamps_q.gnn_r;
    assign ped_n_g  = lamps_q.ped_n_g;
    assign ped_n_r  = lamps_q.ped_n_r;
    assign ped_th_g = lamps_q.ped_th_g;
    assign ped_th_r = lamps_q.ped_th_r;

endmodule
